program_sequencer: RTL

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

---
 rtl/program_sequencer_if.sv | 46 ++++
 rtl/program_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/program_sequencer_if.sv
// program_sequencer_if: control/status bundle for program_sequencer.
//
// Signals (direction as seen by the sequencer):
//   en          in   advance enable; 0 freezes all sequencer state
//   op[2:0]     in   control op (NEXT/JMP/JZ/JNZ/CALL/RET/HALT/RETI)
//   target      in   jump/call destination
//   zero        in   accumulator-zero flag for JZ/JNZ
//   irq         in   level-sensitive interrupt request
//   pc          out  registered program counter
//   halted      out  1 while in HALTED
//   stack_full  out  return stack is full
//   stack_empty out  return stack is empty
//   depth       out  number of stacked return addresses
//   err         out  sticky overflow/underflow flag
//   irq_ack     out  one-cycle pulse on interrupt entry
//
// Modports: master drives the controls (core/testbench), slave is the sequencer.
interface program_sequencer_if #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned STACK_DEPTH = 8
);
    localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic              en;
    logic [2:0]        op;
    logic [ADDR_W-1:0] target;
    logic              zero;
    logic              irq;
    logic [ADDR_W-1:0] pc;
    logic              halted;
    logic              stack_full;
    logic              stack_empty;
    logic [DEPTH_W-1:0] depth;
    logic              err;
    logic              irq_ack;

    modport master (
        output en, op, target, zero, irq,
        input  pc, halted, stack_full, stack_empty, depth, err, irq_ack
    );

    modport slave (
        input  en, op, target, zero, irq,
        output pc, halted, stack_full, stack_empty, depth, err, irq_ack
    );
endinterface

// File: rtl/program_sequencer.sv
// program_sequencer: program counter with return stack, HALT state and optional interrupts.
//
// Ports:
//   clk  single clock, all state changes on the rising edge
//   rst  synchronous active-high reset (overrides en, op and irq)
//   bus  program_sequencer_if.slave: en/op/target/zero/irq in,
//        pc/halted/stack_full/stack_empty/depth/err/irq_ack out
//
// Configuration:
//   SEQ_IRQ_EN  when defined, adds interrupt entry, the ie register and RETI ie-restore.
//               When undefined, irq is ignored, irq_ack is 0 and RETI behaves as RET.
module program_sequencer #(
    parameter int unsigned       ADDR_W      = 8,
    parameter int unsigned       STACK_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
    parameter logic [ADDR_W-1:0] IRQ_VEC     = ADDR_W'('hF0)
) (
    input logic                clk,
    input logic                rst,
    program_sequencer_if.slave bus
);
    localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int unsigned PTR_W   = $clog2(STACK_DEPTH);

    typedef enum logic {StRun, StHalted} state_e;

    typedef enum logic [2:0] {
        OpNext = 3'b000,
        OpJmp  = 3'b001,
        OpJz   = 3'b010,
        OpJnz  = 3'b011,
        OpCall = 3'b100,
        OpRet  = 3'b101,
        OpHalt = 3'b110,
        OpReti = 3'b111
    } op_e;

    state_e             state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [DEPTH_W-1:0] depth_q;
    logic               err_q;
    logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];

    logic [ADDR_W-1:0]  pc_inc;
    logic               full;
    logic               empty;
    logic [DEPTH_W-1:0] depth_m1;
    logic [PTR_W-1:0]   push_ptr;
    logic [PTR_W-1:0]   pop_ptr;
    logic               take_irq;
    logic               irq_blocked;
    logic [ADDR_W-1:0]  irq_ret;

    assign pc_inc   = pc_q + ADDR_W'(1);  // wraps modulo 2^ADDR_W
    assign full     = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign empty    = (depth_q == '0);
    assign depth_m1 = depth_q - DEPTH_W'(1);
    // Push slot is the current depth; top of stack is one below it.
    assign push_ptr = depth_q[PTR_W-1:0];
    assign pop_ptr  = depth_m1[PTR_W-1:0];
    // A halted core has already "executed" the HALT, so it resumes after it.
    assign irq_ret  = (state_q == StHalted) ? pc_inc : pc_q;

`ifdef SEQ_IRQ_EN
    logic ie_q;
    logic irq_ack_q;

    assign take_irq    = bus.irq && ie_q && !full;
    assign irq_blocked = bus.irq && ie_q && full;
    assign bus.irq_ack = irq_ack_q;
`else
    logic unused_irq;

    assign unused_irq  = bus.irq;
    assign take_irq    = 1'b0;
    assign irq_blocked = 1'b0;
    assign bus.irq_ack = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            pc_q    <= RESET_VEC;
            depth_q <= '0;
            err_q   <= 1'b0;
`ifdef SEQ_IRQ_EN
            ie_q      <= 1'b1;
            irq_ack_q <= 1'b0;
`endif
        end else begin
`ifdef SEQ_IRQ_EN
            // Cleared every edge so the acknowledge is always a single-cycle pulse.
            irq_ack_q <= 1'b0;
`endif
            if (bus.en) begin
                if (take_irq) begin
                    // Interrupt entry wins over op; the op of this cycle is dropped.
                    stack_q[push_ptr] <= irq_ret;
                    depth_q           <= depth_q + DEPTH_W'(1);
                    pc_q              <= IRQ_VEC;
                    state_q           <= StRun;
`ifdef SEQ_IRQ_EN
                    ie_q      <= 1'b0;
                    irq_ack_q <= 1'b1;
`endif
                end else begin
                    if (irq_blocked) begin
                        err_q <= 1'b1;
                    end
                    if (state_q == StRun) begin
                        case (bus.op)
                            OpNext: pc_q <= pc_inc;
                            OpJmp:  pc_q <= bus.target;
                            OpJz:   pc_q <= bus.zero ? bus.target : pc_inc;
                            OpJnz:  pc_q <= bus.zero ? pc_inc : bus.target;
                            OpCall: begin
                                if (!full) begin
                                    stack_q[push_ptr] <= pc_inc;
                                    depth_q           <= depth_q + DEPTH_W'(1);
                                    pc_q              <= bus.target;
                                end else begin
                                    pc_q  <= pc_inc;
                                    err_q <= 1'b1;
                                end
                            end
                            OpRet, OpReti: begin
                                if (!empty) begin
                                    pc_q    <= stack_q[pop_ptr];
                                    depth_q <= depth_m1;
                                end else begin
                                    pc_q  <= pc_inc;
                                    err_q <= 1'b1;
                                end
`ifdef SEQ_IRQ_EN
                                // RETI re-enables interrupts even on underflow.
                                if (bus.op == OpReti) begin
                                    ie_q <= 1'b1;
                                end
`endif
                            end
                            OpHalt: state_q <= StHalted;
                            default: pc_q <= pc_q;
                        endcase
                    end
                end
            end
        end
    end

    assign bus.pc          = pc_q;
    assign bus.halted      = (state_q == StHalted);
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
    assign bus.depth       = depth_q;
    assign bus.err         = err_q;
endmodule
